// File: rtl/fb_access_arbiter.sv
// fb_access_arbiter: shares one single-port frame-buffer RAM between the
// display read path (slot 0 of each 4-clk pixel period during active video)
// and the camera/filter write path (all remaining slots). Locks to pix_tick
// and flags off-cadence ticks in a sticky error bit.
// Optional feature: define FB_ARB_QVGA_EN for a 320x240 frame buffer that is
// read 2x2-upscaled; otherwise 640x480 addressing is used.
module fb_access_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_tick,
    input  logic              i_de,
    input  logic [9:0]        i_x_pixel,
    input  logic [9:0]        i_y_pixel,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ready,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [DATA_W-1:0] o_rd_pixel,
    output logic              o_rd_de,
    output logic              o_cadence_err
);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    phase_t              r_phase;
    phase_t              w_phase_nxt;
    logic                r_locked;
    logic                w_locked_nxt;
    logic                r_cadence_err;
    logic                w_cadence_set;
    logic                r_de_s;
    logic [9:0]          r_x_s;
    logic [9:0]          r_y_s;
    logic [DATA_W-1:0]   r_rd_pixel;
    logic                r_rd_de;

    logic                w_rd_slot;
    logic                w_wr_xfer;
    logic [ADDR_W-1:0]   w_xs;
    logic [ADDR_W-1:0]   w_ys;
    logic [ADDR_W-1:0]   w_disp_addr;

    // Display address from the sampled pixel coordinates (shift-add multiply).
`ifdef FB_ARB_QVGA_EN
    assign w_ys        = ADDR_W'(r_y_s[9:1]);
    assign w_xs        = ADDR_W'(r_x_s[9:1]);
    assign w_disp_addr = (w_ys << 8) + (w_ys << 6) + w_xs;
`else
    assign w_ys        = ADDR_W'(r_y_s);
    assign w_xs        = ADDR_W'(r_x_s);
    assign w_disp_addr = (w_ys << 9) + (w_ys << 7) + w_xs;
`endif

    // Phase/lock/error state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase       <= PH0;
            r_locked      <= 1'b0;
            r_cadence_err <= 1'b0;
        end else begin
            r_phase       <= w_phase_nxt;
            r_locked      <= w_locked_nxt;
            r_cadence_err <= r_cadence_err | w_cadence_set;
        end
    end

    // Next phase: any tick restarts at slot 0; only a tick in slot 3 is in cadence.
    always_comb begin
        w_phase_nxt   = r_phase;
        w_locked_nxt  = r_locked;
        w_cadence_set = 1'b0;
        if (!r_locked) begin
            if (i_pix_tick) begin
                w_locked_nxt = 1'b1;
                w_phase_nxt  = PH0;
            end
        end else if (i_pix_tick) begin
            w_phase_nxt   = PH0;
            w_cadence_set = (r_phase != PH3);
        end else begin
            case (r_phase)
                PH0:     w_phase_nxt = PH1;
                PH1:     w_phase_nxt = PH2;
                PH2:     w_phase_nxt = PH3;
                PH3:     w_phase_nxt = PH0;
                default: w_phase_nxt = PH0;
            endcase
        end
    end

    // Sample display timing on every pixel tick for the following slot 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_de_s <= 1'b0;
            r_x_s  <= '0;
            r_y_s  <= '0;
        end else if (i_pix_tick) begin
            r_de_s <= i_de;
            r_x_s  <= i_x_pixel;
            r_y_s  <= i_y_pixel;
        end
    end

    // Capture read data in slot 1 (RAM has one clk of read latency).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_pixel <= '0;
            r_rd_de    <= 1'b0;
        end else if (r_phase == PH1) begin
            r_rd_pixel <= r_de_s ? i_mem_rdata : '0;
            r_rd_de    <= r_de_s;
        end
    end

    assign w_rd_slot  = r_locked && (r_phase == PH0) && r_de_s;
    assign o_wr_ready = r_locked && !w_rd_slot;
    assign w_wr_xfer  = i_wr_valid && o_wr_ready;

    // RAM port mux: display read has the slot-0 priority, else a granted write.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_rd_slot) begin
            o_mem_en   = 1'b1;
            o_mem_addr = w_disp_addr;
        end else if (w_wr_xfer) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
        end
    end

    assign o_rd_pixel    = r_rd_pixel;
    assign o_rd_de       = r_rd_de;
    assign o_cadence_err = r_cadence_err;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Scoreboard bench for fb_access_arbiter: stimulus pushes expected RAM
// accesses and display outputs into queues; a monitor compares each cycle.
module tb_fb_access_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;

`ifdef FB_ARB_QVGA_EN
    localparam logic [AW-1:0] EXP_ADDR = 19'd322;
    localparam logic [DW-1:0] EXP_PIX  = 16'h5B18;
`else
    localparam logic [AW-1:0] EXP_ADDR = 19'd1285;
    localparam logic [DW-1:0] EXP_PIX  = 16'h5F5F;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_pix_tick = 1'b0;
    logic          i_de = 1'b0;
    logic [9:0]    i_x = '0;
    logic [9:0]    i_y = '0;
    logic          i_wr_valid = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          o_wr_ready, o_mem_en, o_mem_we, o_rd_de, o_cadence_err;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata, o_rd_pixel;

    fb_access_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_tick(i_pix_tick), .i_de(i_de),
        .i_x_pixel(i_x), .i_y_pixel(i_y), .i_wr_valid(i_wr_valid),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
        .o_rd_pixel(o_rd_pixel), .o_rd_de(o_rd_de), .o_cadence_err(o_cadence_err)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wd;} mexp_t;
    typedef struct {int cyc; logic de; logic [DW-1:0] pix;} rexp_t;

    mexp_t         mq[$];
    rexp_t         rq[$];
    logic [DW-1:0] mem[int];
    logic [DW-1:0] shadow[int];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    // bench-side expectation state
    bit            lk_e = 0, err_e = 0, de_t = 0, last_gnt = 0;
    int            since = 0;
    int            g_dut = 0;
    logic [9:0]    x_t = '0, y_t = '0;
    logic [AW-1:0] wa = 19'h40000;
    logic [DW-1:0] wd = 16'h1000;
    logic          rcur_de = 1'b0;
    logic [DW-1:0] rcur_pix = '0;

    function automatic logic [DW-1:0] mem_rd(input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        return mem.exists(a) ? mem[a] : (av[15:0] ^ 16'h5A5A);
    endfunction

    function automatic logic [DW-1:0] sh_rd(input int a);
        logic [AW-1:0] av;
        av = AW'(a);
        return shadow.exists(a) ? shadow[a] : (av[15:0] ^ 16'h5A5A);
    endfunction

    function automatic logic [AW-1:0] disp(input logic [9:0] x, input logic [9:0] y);
        int a;
`ifdef FB_ARB_QVGA_EN
        a = (int'(y) / 2) * 320 + int'(x) / 2;
`else
        a = int'(y) * 640 + int'(x);
`endif
        return AW'(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clk period of stimulus; expectations for this period are pushed here.
    task automatic step(input logic tick, input logic de, input logic [9:0] x,
                        input logic [9:0] y, input logic wv);
        int ph;
        bit rslot, rdy;
        @(posedge clk);
        #1;
        ph    = (since + 3) % 4;
        rslot = lk_e && (ph == 0) && de_t;
        rdy   = lk_e && !rslot;
        i_pix_tick = tick; i_de = de; i_x = x; i_y = y;
        i_wr_valid = wv; i_wr_addr = wa; i_wr_data = wd;
        last_gnt = 0;
        if (rslot)
            mq.push_back('{cyc, 1'b0, disp(x_t, y_t), '0});
        if (lk_e && ph == 0)
            rq.push_back('{cyc + 2, de_t, de_t ? sh_rd(int'(disp(x_t, y_t))) : '0});
        if (wv && rdy) begin
            mq.push_back('{cyc, 1'b1, wa, wd});
            shadow[int'(wa)] = wd;
            wa = wa + 19'd1;
            wd = wd + 16'h0101;
            last_gnt = 1;
        end
        #1;
        chk("wr_ready", 32'(o_wr_ready), 32'(rdy));
        chk("cadence_err", 32'(o_cadence_err), 32'(err_e));
        if (o_wr_ready && i_wr_valid) g_dut++;
        if (tick) begin
            if (lk_e && ph != 3) err_e = 1;
            lk_e = 1; since = 1; de_t = de; x_t = x; y_t = y;
        end else if (lk_e) begin
            since++;
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wr_ready"}, 32'(o_wr_ready), 32'd0);
        chk({nm, "_mem_en"}, 32'(o_mem_en), 32'd0);
        chk({nm, "_mem_we"}, 32'(o_mem_we), 32'd0);
        chk({nm, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
        chk({nm, "_mem_wdata"}, 32'(o_mem_wdata), 32'd0);
        chk({nm, "_rd_pixel"}, 32'(o_rd_pixel), 32'd0);
        chk({nm, "_rd_de"}, 32'(o_rd_de), 32'd0);
        chk({nm, "_cadence_err"}, 32'(o_cadence_err), 32'd0);
    endtask

    // cycle counter and RAM model (one clk read latency)
    initial forever begin
        @(posedge clk);
        cyc <= cyc + 1;
        if (o_mem_en) begin
            if (o_mem_we) mem[int'(o_mem_addr)] = o_mem_wdata;
            else          i_mem_rdata <= mem_rd(int'(o_mem_addr));
        end
    end

    // monitor: display outputs every cycle, RAM accesses whenever presented
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rcur_de  = 1'b0;
            rcur_pix = '0;
        end
        while (rq.size() > 0 && rq[0].cyc <= cyc) begin
            rcur_de  = rq[0].de;
            rcur_pix = rq[0].pix;
            void'(rq.pop_front());
        end
        n_cmp++;
        if (o_rd_de !== rcur_de || o_rd_pixel !== rcur_pix) begin
            n_bad++;
            $display("FAIL rd_out: got de=%0b pix=%0h expected de=%0b pix=%0h (cycle %0d)",
                     o_rd_de, o_rd_pixel, rcur_de, rcur_pix, cyc);
        end
        while (mq.size() > 0 && mq[0].cyc < cyc) begin
            n_cmp++; n_bad++;
            $display("FAIL mem_missing: got no access expected we=%0b addr=%0h (cycle %0d)",
                     mq[0].we, mq[0].addr, mq[0].cyc);
            void'(mq.pop_front());
        end
        if (mq.size() > 0 && mq[0].cyc == cyc) begin
            n_cmp++;
            if (o_mem_en !== 1'b1 || o_mem_we !== mq[0].we || o_mem_addr !== mq[0].addr ||
                o_mem_wdata !== mq[0].wd) begin
                n_bad++;
                $display("FAIL mem_access: got en=%0b we=%0b addr=%0h wd=%0h expected en=1 we=%0b addr=%0h wd=%0h (cycle %0d)",
                         o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
                         mq[0].we, mq[0].addr, mq[0].wd, cyc);
            end
            void'(mq.pop_front());
        end else if (o_mem_en) begin
            n_cmp++; n_bad++;
            $display("FAIL mem_unexpected: got we=%0b addr=%0h expected no access (cycle %0d)",
                     o_mem_we, o_mem_addr, cyc);
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        // reset with a pending write request: no access may occur
        repeat (3) step(0, 0, 0, 0, 1);
        chk_all_zero("reset");
        rst_n = 1'b1;
        // unlocked: request held, never granted
        repeat (3) step(0, 1, 10'd5, 10'd2, 1);
        // first tick locks; active video with continuous writes
        step(1, 1, 10'd5, 10'd2, 1);
        g_dut = 0;
        for (int k = 0; k < 16; k++) begin
            step(k % 4 == 3, 1, 10'd5, 10'd2, 1);
            if (k == 0) begin
                chk("first_rd_addr", 32'(o_mem_addr), 32'(EXP_ADDR));
                chk("first_rd_we", 32'(o_mem_we), 32'd0);
            end
            if (k == 2) begin
                chk("first_rd_pixel", 32'(o_rd_pixel), 32'(EXP_PIX));
                chk("first_rd_de", 32'(o_rd_de), 32'd1);
            end
        end
        chk("grants_active", 32'(g_dut), 32'd12);
        // transition into blanking, then full-rate writes
        for (int k = 0; k < 4; k++) step(k % 4 == 3, 0, 10'd0, 10'd0, 1);
        g_dut = 0;
        for (int k = 0; k < 16; k++) step(k % 4 == 3, 0, 10'd0, 10'd0, 1);
        chk("grants_blank", 32'(g_dut), 32'd16);
        chk("blank_rd_pixel", 32'(o_rd_pixel), 32'd0);
        chk("blank_rd_de", 32'(o_rd_de), 32'd0);
        // active video with changing coordinates and bursty writes
        for (int k = 0; k < 16; k++)
            step(k % 4 == 3, 1, 10'(100 + k / 4), 10'd7, logic'(k % 2));
        // off-cadence tick in phase 1, then regular cadence resumes
        step(0, 1, 10'd200, 10'd9, 1);
        step(1, 1, 10'd201, 10'd9, 1);
        step(0, 1, 10'd201, 10'd9, 1);
        chk("resync_read_we", 32'(o_mem_we), 32'd0);
        chk("resync_read_addr", 32'(o_mem_addr), 32'(disp(10'd201, 10'd9)));
        for (int k = 0; k < 11; k++) step(k % 4 == 2, 1, 10'd202, 10'd9, 1);
        chk("cadence_sticky", 32'(o_cadence_err), 32'd1);
        // reset while a write stream is in flight
        step(0, 1, 10'd202, 10'd9, 1);
        step(0, 1, 10'd202, 10'd9, 1);
        rst_n = 1'b0;
        if (last_gnt) begin
            wa = wa - 19'd1;
            wd = wd - 16'h0101;
            shadow.delete(int'(wa));
        end
        mq.delete();
        rq.delete();
        lk_e = 0; err_e = 0; since = 0; de_t = 0;
        #1;
        chk_all_zero("reset_mid");
        repeat (3) step(0, 1, 10'd0, 10'd0, 1);
        rst_n = 1'b1;
        repeat (2) step(0, 0, 10'd0, 10'd0, 1);
        step(1, 0, 10'd0, 10'd0, 1);
        for (int k = 0; k < 8; k++) step(k % 4 == 3, 0, 10'd0, 10'd0, 1);
        for (int k = 0; k < 4; k++) step(k % 4 == 3, 0, 10'd0, 10'd0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("mem_queue_drained", 32'(mq.size()), 32'd0);
        chk("rd_queue_drained", 32'(rq.size()), 32'd0);
        foreach (shadow[a]) chk("ram_content", 32'(mem_rd(a)), 32'(shadow[a]));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Shares one single-port synchronous frame-buffer RAM between the VGA display read path and the camera/filter write path. Runs on the 100 MHz system clock and locks to the 1-in-4 pixel tick from the pixel clock generator. Each pixel period has four clk slots: the display read is issued in slot 0 during active video, and writes use the other slots. It sits between the VGA timing decoder, the filter write stage and the frame-buffer BRAM.

## Interface
- DATA_W, 16: pixel width (RGB565).
- ADDR_W, 19: frame-buffer address width.
- clk  in  1  100 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- pix_tick  in  1  one-clk pulse every 4 clk (pixel enable).
- de  in  1  display-enable from the VGA decoder.
- x_pixel  in  10  display column.
- y_pixel  in  10  display row.
- wr_valid  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  write accepted this cycle.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 clk after a read.
- rd_pixel  out  DATA_W  pixel to the display.
- rd_de  out  1  rd_pixel lies in active video.
- cadence_err  out  1  sticky flag: pix_tick arrived off-cadence.

## Operation
- Internal state: phase[1:0], locked, and de_s/x_s/y_s, which are sampled on every clk where pix_tick=1.
- Locking: after reset, locked=0, wr_ready=0 and no RAM access occurs. The first pix_tick sets locked=1 and phase=0 on the next clk.
- Phase sequence: 0 → 1 → 2 → 3 → 0. A pix_tick seen in phase 3 is in cadence.
- Off-cadence tick: a pix_tick in phase 0–2 forces phase=0 on the next clk and sets cadence_err.
- Slot 0 with de_s=1: display read. mem_en=1, mem_we=0, mem_addr=display address, wr_ready=0.
- Slot 0 with de_s=0: behaves as a write slot.
- Slots 1–3: write slots. wr_ready=locked.
- Write transfer occurs when wr_valid && wr_ready. In the same cycle, mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
- mem_*, wr_ready: combinational from registered state and wr_*.
- mem_* outside a transfer: mem_en=0, mem_we=0, addr/wdata=0.
- Read capture in phase 1: rd_pixel <= de_s ? mem_rdata : 0, and rd_de <= de_s. Both hold until the next phase-1 capture.
- Display address without the macro: y_s*640 + x_s, computed as (y_s<<9)+(y_s<<7)+x_s, zero-extended to ADDR_W.
- Writer address: the arbiter does not range-check wr_addr.
- Reset values: phase=0, locked=0, de_s=0, x_s=0, y_s=0, rd_pixel=0, rd_de=0, cadence_err=0. All outputs are 0 during reset.
- Reset mid-transfer: any in-flight write is abandoned and the writer must re-present it. rd_pixel clears immediately.

## Timing
- Tick at clk T:
  - T+1: phase 0, read issued.
  - T+2: phase 1, mem_rdata valid and captured.
  - T+3: rd_pixel/rd_de updated.
- Read latency is 3 clk from the pix_tick that sampled x/y.
- Write throughput:
  - Active video: up to 3 writes per 4 clk.
  - Blanking: 4 writes per 4 clk.
  - A back-to-back wr_valid is never stalled more than 1 clk once locked.
- Simultaneous pix_tick and write in phase 3: the write is granted. The tick only samples x/y/de for the next slot 0.
- wr_valid asserted while locked=0: wr_ready stays 0 and the request is held.

## Configuration
- FB_ARB_QVGA_EN defined: frame buffer is 320×240.
  - Display address is (y_s>>1)*320 + (x_s>>1), computed as ((y_s>>1)<<8)+((y_s>>1)<<6)+(x_s>>1).
  - Each stored pixel is therefore read for a 2×2 screen block.
- FB_ARB_QVGA_EN undefined: full 640×480 addressing as described in Operation.

## Test plan
- Reset released, pix_tick every 4 clk, de=1, x=5, y=2:
  - mem_addr=1285 with mem_we=0 at T+1.
  - rd_pixel equals the RAM content at 1285 at T+3.
  - With QVGA, mem_addr=322.
- wr_valid held high with incrementing wr_addr during active video: exactly 3 grants per 4 clk, never in slot 0; all data lands in the RAM model.
- Same as above with de=0: 4 grants per 4 clk.
- rd_pixel checks:
  - rd_pixel=0 and rd_de=0 during blanking.
  - Holds a stable value across the 4 clk between captures.
- Off-cadence pix_tick in phase 1: phase resyncs to 0 next clk, cadence_err=1 and stays set, reads resume correctly.
- Reset asserted while wr_valid is mid-stream:
  - All outputs 0 immediately; wr_ready=0 until the first pix_tick after release.
  - No RAM write occurs while reset is asserted.
